// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Definitions shared by the BIST test-pattern generator and its Galois
// register sub-module:
//   - bist_state_e : run-control states (IDLE, RUN, FLUSH, DONE)
//   - POLY_DEFAULT / SEED_DEFAULT : default tap mask (x^4+x+1) and LFSR seed
//   - galois_step  : one shift of a Galois LFSR of run-time width w
// -----------------------------------------------------------------------------
package bist_pkg;

  // Widest register galois_step can handle.
  localparam int MAX_W = 32;

  localparam logic [3:0] POLY_DEFAULT = 4'b0011;
  localparam logic [3:0] SEED_DEFAULT = 4'b0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  // Shift left by one within w bits; if the bit shifted out was set, fold the
  // tap mask back in. Operands are zero-extended to MAX_W so that one function
  // serves every register width.
  function automatic logic [MAX_W-1:0] galois_step(input logic [MAX_W-1:0] x,
                                                   input logic [MAX_W-1:0] poly,
                                                   input int               w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] shifted;
    logic             msb;
    mask    = ~({MAX_W{1'b1}} << w);
    msb     = |(x & (MAX_W'(1) << (w - 1)));
    shifted = (x << 1) & mask;
    return msb ? (shifted ^ (poly & mask)) : shifted;
  endfunction

endpackage

// File: rtl/bist_galois_reg.sv
// -----------------------------------------------------------------------------
// bist_galois_reg
// WIDTH-bit Galois shift register with parallel load and an xor input.
// Serves as the pattern LFSR (xor_in tied to zero) and as the response MISR
// (xor_in = CUT response).
// Ports:
//   clk      : clock, rising edge
//   load     : load load_val this cycle (takes priority over en)
//   load_val : value written on load
//   en       : advance q <= step(q) ^ xor_in
//   xor_in   : value folded in on each advance
//   q        : register contents
// -----------------------------------------------------------------------------
module bist_galois_reg
  import bist_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] xor_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] step_val;

  assign step_val = WIDTH'(galois_step(MAX_W'(q), MAX_W'(POLY), WIDTH));

  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= step_val ^ xor_in;
    end
  end

endmodule

// File: rtl/bist_tpg.sv
// -----------------------------------------------------------------------------
// bist_tpg
// BIST pattern generator and response compactor. A start pulse launches a run
// of NUM_PAT pseudo-random patterns (Galois LFSR) handed to the CUT over a
// valid/ready handshake. Each response, arriving one clock after its pattern
// was accepted, is folded into a MISR; after the last response the signature
// is compared against GOLDEN.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous reset, active low
//   start     : run request, honoured only in IDLE or DONE
//   pat_ready : CUT accepts pat_out this cycle
//   resp_in   : CUT response, valid one clock after each accepted pattern
//   pat_out   : current pattern (LFSR contents)
//   pat_valid : pat_out is valid (RUN)
//   busy      : RUN or FLUSH
//   done      : run complete, pass and sig_out final
//   pass      : final signature equals GOLDEN
//   sig_out   : MISR contents
// -----------------------------------------------------------------------------
module bist_tpg
  import bist_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(POLY_DEFAULT),
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(SEED_DEFAULT),
  parameter int               NUM_PAT = 15,
  parameter logic [WIDTH-1:0] GOLDEN  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pat_ready,
  input  logic [WIDTH-1:0] resp_in,
  output logic [WIDTH-1:0] pat_out,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig_out
);

  localparam int CNT_W = $clog2(NUM_PAT + 1);

  if (SEED == '0) begin : g_bad_seed
    $error("bist_tpg: SEED must be nonzero, an all-zero LFSR never advances");
  end
  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("bist_tpg: WIDTH out of range");
  end
  if (NUM_PAT < 1) begin : g_bad_num_pat
    $error("bist_tpg: NUM_PAT must be at least 1");
  end

  bist_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             resp_v_q;
  logic             fire;
  logic             start_acc;
  logic             last_pat;
  logic             reg_load;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] misr_q;

  assign fire      = (state_q == RUN) & pat_ready;
  assign start_acc = start & ((state_q == IDLE) | (state_q == DONE));
  assign last_pat  = (cnt_q == CNT_W'(NUM_PAT - 1));
  // Reset and run start both reinitialise the two data registers.
  assign reg_load  = ~rst | start_acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      resp_v_q <= 1'b0;
    end else begin
      resp_v_q <= fire;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_pat) state_q <= FLUSH;
          end
        end
        FLUSH:   state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  bist_galois_reg #(.WIDTH(WIDTH), .POLY(POLY)) u_lfsr (
    .clk      (clk),
    .load     (reg_load),
    .load_val (SEED),
    .en       (fire),
    .xor_in   ('0),
    .q        (lfsr_q)
  );

  // resp_v_q marks the cycle in which resp_in belongs to an accepted pattern,
  // so the compactor runs in any state, including FLUSH.
  bist_galois_reg #(.WIDTH(WIDTH), .POLY(POLY)) u_misr (
    .clk      (clk),
    .load     (reg_load),
    .load_val ('0),
    .en       (resp_v_q),
    .xor_in   (resp_in),
    .q        (misr_q)
  );

  assign pat_out   = lfsr_q;
  assign pat_valid = (state_q == RUN);
  assign busy      = (state_q == RUN) | (state_q == FLUSH);
  assign done      = (state_q == DONE);
  assign sig_out   = misr_q;
  // In DONE the MISR holds the signature absorbed during FLUSH and cannot move
  // (no pattern fires), so comparing it here equals a compare taken at FLUSH.
  assign pass      = done & (misr_q == GOLDEN);

endmodule

// File: tb/tb_bist_tpg.sv
module tb_bist_tpg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  // Default-parameter instance, identity CUT.
  logic       rst0, start0, rdy0;
  logic [3:0] resp0, pat0, sig0;
  logic       pv0, busy0, done0, pass0;

  bist_tpg u0 (
    .clk(clk), .rst(rst0), .start(start0), .pat_ready(rdy0), .resp_in(resp0),
    .pat_out(pat0), .pat_valid(pv0), .busy(busy0), .done(done0), .pass(pass0),
    .sig_out(sig0)
  );
  always @(posedge clk) resp0 <= pat0;

  // Two NUM_PAT=5 instances differing only in GOLDEN, sharing stimulus.
  logic       rst5, start5, rdy5, inv5;
  logic [3:0] resp_a, pat_a, sig_a, resp_b, pat_b, sig_b;
  logic       pv_a, busy_a, done_a, pass_a, pv_b, busy_b, done_b, pass_b;

  bist_tpg #(.NUM_PAT(5), .GOLDEN(4'b1011)) ua (
    .clk(clk), .rst(rst5), .start(start5), .pat_ready(rdy5), .resp_in(resp_a),
    .pat_out(pat_a), .pat_valid(pv_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .sig_out(sig_a)
  );
  bist_tpg #(.NUM_PAT(5), .GOLDEN(4'b1010)) ub (
    .clk(clk), .rst(rst5), .start(start5), .pat_ready(rdy5), .resp_in(resp_b),
    .pat_out(pat_b), .pat_valid(pv_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .sig_out(sig_b)
  );
  always @(posedge clk) begin
    resp_a <= inv5 ? ~pat_a : pat_a;
    resp_b <= inv5 ? ~pat_b : pat_b;
  end

  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of u0: patterns are successive powers of x in GF(16)
  // modulo x^4+x+1 (binary 10011); the signature is sig*x + response.
  int tbl[15];
  function automatic int mulx(input int v);
    int r;
    r = v * 2;
    if (r >= 16) r = r ^ 19;
    return r;
  endfunction

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 15; i++) begin
      tbl[i] = v;
      v = mulx(v);
    end
  end

  int m_st;     // 0 idle, 1 run, 2 flush, 3 done
  int m_idx;    // patterns consumed in this run
  int m_sig;
  bit m_pend;   // a response is due on the next edge
  int m_pval;
  bit m_live = 1'b0;

  always @(posedge clk) begin
    int  sig_n;
    bit  f;
    if (rst0 === 1'b0) begin
      m_st = 0; m_idx = 0; m_sig = 0; m_pend = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      f      = (m_st == 1) && (rdy0 === 1'b1);
      sig_n  = m_pend ? (mulx(m_sig) ^ m_pval) : m_sig;
      m_pend = f;
      m_pval = tbl[m_idx % 15];
      m_sig  = sig_n;
      case (m_st)
        0, 3: if (start0 === 1'b1) begin m_st = 1; m_idx = 0; m_sig = 0; end
        1: if (f) begin m_idx++; if (m_idx == 15) m_st = 2; end
        2: m_st = 3;
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model pat_out", int'(pat0), tbl[m_idx % 15]);
      check("model pat_valid", int'(pv0), int'(m_st == 1));
      check("model busy", int'(busy0), int'(m_st == 1 || m_st == 2));
      check("model done", int'(done0), int'(m_st == 3));
      check("model pass", int'(pass0), int'(m_st == 3 && m_sig == 0));
      check("model sig_out", int'(sig0), m_sig);
    end
  end

  logic [3:0] exp_seq[15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                              4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
  logic [3:0] rtbl[5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hC};
  logic [3:0] stbl[5] = '{4'hE, 4'h2, 4'hF, 4'hA, 4'hB};

  // Full default run on u0 with pat_ready high; optionally pulse start mid-run.
  task automatic run_u0(input bit mid_start, output logic [3:0] sig);
    int cyc;
    int nv;
    bit got_done;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0; nv = 0; got_done = 1'b0;
    check("done after start", int'(done0), 0);
    while (!got_done && cyc < 40) begin
      if (pv0) begin
        if (nv < 15) check("pattern sequence", int'(pat0), int'(exp_seq[nv]));
        nv++;
      end
      start0 = (mid_start && cyc == 5);
      if (done0) got_done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start0 = 1'b0;
    check("done latency", cyc, 16);
    check("pat_valid cycles", nv, 15);
    sig = sig0;
  endtask

  initial begin
    logic [3:0] s1, s2;
    int         cnt;
    rst0 = 1'b0; start0 = 1'b0; rdy0 = 1'b1;
    rst5 = 1'b0; start5 = 1'b0; rdy5 = 1'b1; inv5 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset pat_out", int'(pat0), 1);
    check("reset pat_valid", int'(pv0), 0);
    check("reset busy", int'(busy0), 0);
    check("reset done", int'(done0), 0);
    check("reset pass", int'(pass0), 0);
    check("reset sig_out", int'(sig0), 0);
    rst0 = 1'b1; rst5 = 1'b1;
    @(negedge clk);

    // Test 1: the 15 x^k terms each contribute x^14, an odd count -> 1001.
    run_u0(1'b0, s1);
    check("t1 final sig", int'(s1), 9);
    check("t1 pass", int'(pass0), 0);

    // Test 4: reset in RUN after three patterns.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    check("t4 pat before reset", int'(pat0), 8);
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    check("t4 pat_out", int'(pat0), 1);
    check("t4 pat_valid", int'(pv0), 0);
    check("t4 busy", int'(busy0), 0);
    check("t4 done", int'(done0), 0);
    check("t4 sig_out", int'(sig0), 0);
    check("t4 pass", int'(pass0), 0);
    run_u0(1'b0, s1);
    check("t4 rerun sig", int'(s1), 9);

    // Test 5: start during RUN ignored, then restart from DONE.
    run_u0(1'b1, s1);
    check("t5 sig with mid start", int'(s1), 9);
    run_u0(1'b0, s2);
    check("t5 restart sig matches", int'(s2), int'(s1));

    // Test 2: NUM_PAT=5, registered inverter CUT.
    inv5 = 1'b1;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j <= 5) check("t2 response", int'(resp_a), int'(rtbl[j-1]));
      if (j >= 2) check("t2 sig step", int'(sig_a), int'(stbl[j-2]));
    end
    check("t2 done", int'(done_a), 1);
    check("t2 pass golden 1011", int'(pass_a), 1);
    check("t2 done golden 1010", int'(done_b), 1);
    check("t2 sig golden 1010", int'(sig_b), 11);
    check("t2 pass golden 1010", int'(pass_b), 0);

    // Test 3: identity CUT, 3-cycle stall while 0010 is presented.
    inv5 = 1'b0;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    @(negedge clk);
    check("t3 second pattern", int'(pat_a), 2);
    rdy5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3 stall pat_out", int'(pat_a), 2);
      check("t3 stall pat_valid", int'(pv_a), 1);
    end
    rdy5 = 1'b1;
    cnt = 0;
    while (!done_a && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("t3 cycles to done", cnt, 5);
    check("t3 sig", int'(sig_a), 3);
    check("t3 sig second inst", int'(sig_b), 3);
    check("t3 pass", int'(pass_a), 0);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule

// File: doc/bist_tpg.md
Name: bist_tpg

Overview:
- Test-pattern-generator side of the on-chip BIST loop; the response compactor is the receiving end.
- Generates a pseudo-random pattern stream from a Galois LFSR and drives it to the circuit-under-test (CUT) with a valid/ready handshake.
- Compacts the CUT responses into an internal MISR signature and compares the final signature against a golden value, reporting pass/fail.

Parameters:
- WIDTH, 4, pattern/response/signature width (>=2).
- POLY, 4'b0011, Galois tap mask without the x^WIDTH term (default x^4+x+1). Shared by the LFSR and the MISR.
- SEED, 4'b0001, LFSR load value; must be nonzero.
- NUM_PAT, 15, patterns per run; must be >=1. Values above 2^WIDTH-1 simply wrap the sequence.
- GOLDEN, 4'b0000, expected final signature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE or DONE.
- pat_ready  in  1  CUT accepts pat_out this cycle.
- resp_in  in  WIDTH  CUT response; valid exactly one clock after each accepted pattern.
- pat_out  out  WIDTH  current pattern (LFSR state).
- pat_valid  out  1  pat_out is valid.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  run complete; pass and sig_out are final.
- pass  out  1  final signature == GOLDEN.
- sig_out  out  WIDTH  MISR contents.

Behaviour:
- Reset (rst=0 at an edge), from any state including mid-run: state=IDLE; lfsr=SEED; misr=0; cnt=0; resp_v=0; pass=0. All outputs are then 0, except pat_out, which equals lfsr and therefore reads SEED.
- Galois step, used for both registers: step(x) = {x[WIDTH-2:0],1'b0} ^ (x[WIDTH-1] ? POLY : 0).
- Handshake: fire = pat_valid & pat_ready.
  - pat_out is held stable while pat_valid=1 and pat_ready=0.
  - A pattern is consumed only on fire.
- States:
  - IDLE: all outputs low. start=1 -> lfsr<=SEED, misr<=0, cnt<=0, -> RUN.
  - RUN: pat_valid=1, busy=1. On fire: lfsr<=step(lfsr), cnt<=cnt+1. If cnt==NUM_PAT-1 on fire -> FLUSH. No fire -> hold all.
  - FLUSH: pat_valid=0, busy=1. Exactly one cycle, to absorb the last response. -> DONE; pass<=(misr_next==GOLDEN).
  - DONE: done=1; pass and sig_out held. start=1 -> restart exactly as from IDLE (done drops the next cycle).
- start is ignored while in RUN or FLUSH.
- Response path: resp_v <= fire every cycle. Whenever resp_v=1: misr<=step(misr)^resp_in, in any state.
  - Responses arriving with resp_v=0 are ignored.
- Latency with pat_ready tied high: start edge E0, RUN fires on E1..E_NUM_PAT, FLUSH edge E_NUM_PAT+1, done high from then on.
- cnt width: clog2(NUM_PAT+1). No overflow is possible.
- The LFSR never reaches zero given a nonzero SEED. SEED=0 is illegal and must be caught by an elaboration-time check.

Decomposition:
- Package bist_pkg holds:
  - the state enum {IDLE, RUN, FLUSH, DONE};
  - default POLY/SEED constants;
  - a galois_step function.
- One sub-module, bist_galois_reg: WIDTH-bit register with load, enable, and xor input. It is instantiated twice:
  - as the LFSR, with xor input = 0;
  - as the MISR, with xor input = resp_in.

Test Plan:
1. Default parameters, pat_ready=1, CUT = 1-cycle register (resp_in = pat_out delayed 1), start pulse.
   - Required: pat_out sequence 0001,0010,0100,1000,0011,0110,1100,1011,0101,1010,0111,1110,1111,1101,1001 with pat_valid high for exactly 15 cycles.
   - Required: done exactly 16 clocks after the start edge.
2. NUM_PAT=5, CUT = registered inverter, GOLDEN=4'b1011.
   - Required: responses 1110,1101,1011,0111,1100.
   - Required: sig_out steps 1110,0010,1111,1010,1011; final pass=1.
   - Rerun with GOLDEN=4'b1010 -> pass=0.
3. NUM_PAT=5, identity CUT, pat_ready low for 3 cycles after the 2nd pattern.
   - Required: pat_out holds 0010 during the stall; cnt frozen.
   - Required: sig_out = 0011 at done, identical to the unstalled run.
4. Reset asserted while in RUN after 3 patterns.
   - Required: next cycle all outputs 0 except pat_out=SEED; done=0; sig_out=0.
   - A following start produces the full sequence from 0001.
5. start pulsed during RUN (ignored, no change to the sequence). Then start in DONE.
   - Required: done drops next cycle; the sequence restarts at 0001; the final signature matches the first run.
